// File: rtl/serial_add_sub_pkg.sv
// serial_add_sub_pkg: shared types for the bit-serial adder/subtractor.
// Holds FSM state encoding and the operation select constants.
package serial_add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder_1b.sv
// full_adder_1b: one-bit full adder built from two half adders and an OR.
// Ports: a, b, cin -> sum, cout (all 1 bit, purely combinational).
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    // First half adder: a + b
    assign w_s1 = a ^ b;
    assign w_c1 = a & b;

    // Second half adder: partial sum + cin
    assign sum  = w_s1 ^ cin;
    assign w_c2 = w_s1 & cin;

    assign cout = w_c1 | w_c2;

endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial add/subtract, one bit pair per clock, LSB first.
// Ports: clk, rst_n (async low), start/sub/a/b in; ready/busy/done,
//        result/carry_out out. Optional ovf port with SERIAL_ADD_SUB_OVF_EN.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
`ifdef SERIAL_ADD_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_sr;
    logic             r_cy;
    logic [CW-1:0]    r_cnt;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;

    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_sr_next;

    full_adder_1b u_fa (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .cin  (r_cy),
        .sum  (w_s),
        .cout (w_c)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 is the LSB.
    generate
        if (WIDTH == 1) begin : g_sr1
            assign w_sr_next = w_s;
        end else begin : g_srn
            assign w_sr_next = {w_s, r_sr[WIDTH-1:1]};
        end
    endgenerate

`ifdef SERIAL_ADD_SUB_OVF_EN
    logic r_ovf;
`endif

    // Result, carry and done are registered on the final SHIFT edge so
    // they are all valid together during the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_sr     <= '0;
            r_cy     <= 1'b0;
            r_cnt    <= '0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= (sub == OP_SUB) ? ~b : b;
                        // Subtract: a + ~b + 1
                        r_cy    <= (sub == OP_SUB);
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_sr  <= w_sr_next;
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_cy  <= w_c;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state  <= DONE;
                        r_done   <= 1'b1;
                        r_result <= w_sr_next;
                        r_cout   <= w_c;
`ifdef SERIAL_ADD_SUB_OVF_EN
                        // carry into MSB xor carry out of MSB
                        r_ovf    <= r_cy ^ w_c;
`endif
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ready     = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign carry_out = r_cout;
`ifdef SERIAL_ADD_SUB_OVF_EN
    assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed, table-driven bench for serial_add_sub.
// WIDTH=8; ovf vectors are included when SERIAL_ADD_SUB_OVF_EN is defined.
module tb_serial_add_sub;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
`ifdef SERIAL_ADD_SUB_OVF_EN
    logic         ovf;
`endif

    int tests;
    int fails;
    int done_cnt;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out)
`ifdef SERIAL_ADD_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // done is counted from its pre-edge value at each rising edge
    always @(posedge clk) begin
        if (rst_n && done) done_cnt++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] r;
        logic         c;
    } vec_t;

    vec_t vecs[8];

    // Launch one operation, scramble inputs while busy, check outcome.
    task automatic do_op(input string nm, input logic [W-1:0] ia,
                         input logic [W-1:0] ib, input logic isub,
                         input logic [W-1:0] er, input logic ec);
        int lat;
        int d0;
        logic [W-1:0] prev_r;
        logic prev_c;
        int stable;
        @(negedge clk);
        chk({nm, "_ready_pre"}, int'(ready), 1);
        prev_r = result;
        prev_c = carry_out;
        a = ia;
        b = ib;
        sub = isub;
        start = 1'b1;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        sub = 1'($urandom);
        lat = 0;
        stable = 1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (result !== prev_r || carry_out !== prev_c) stable = 0;
            if (busy !== 1'b1 || ready !== 1'b0) stable = 0;
        end
        chk({nm, "_latency"}, lat, W + 1);
        chk({nm, "_hold"}, stable, 1);
        chk({nm, "_result"}, int'(result), int'(er));
        chk({nm, "_carry"}, int'(carry_out), int'(ec));
        @(negedge clk);
        chk({nm, "_ready_post"}, int'(ready), 1);
        chk({nm, "_busy_post"}, int'(busy), 0);
        chk({nm, "_done_cnt"}, done_cnt - d0, 1);
    endtask

    initial begin
        int d0;
        int lat;
        tests = 0;
        fails = 0;
        done_cnt = 0;
        rst_n = 1'b0;
        start = 1'b0;
        sub = 1'b0;
        a = '0;
        b = '0;

        vecs[0] = '{8'd3,   8'd5,   1'b0, 8'd8,   1'b0};
        vecs[1] = '{8'd200, 8'd100, 1'b0, 8'd44,  1'b1};
        vecs[2] = '{8'd5,   8'd3,   1'b1, 8'd2,   1'b1};
        vecs[3] = '{8'd3,   8'd5,   1'b1, 8'd254, 1'b0};
        vecs[4] = '{8'd255, 8'd1,   1'b0, 8'd0,   1'b1};
        vecs[5] = '{8'd0,   8'd0,   1'b1, 8'd0,   1'b1};
        vecs[6] = '{8'd0,   8'd1,   1'b1, 8'd255, 1'b0};
        vecs[7] = '{8'd170, 8'd85,  1'b0, 8'd255, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_ready", int'(ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_carry", int'(carry_out), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                  vecs[i].sub, vecs[i].r, vecs[i].c);
        end

        // Second start while busy must be ignored.
        @(negedge clk);
        a = 8'd1;
        b = 8'd1;
        sub = 1'b0;
        start = 1'b1;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 2) begin
                start = 1'b1;
                a = 8'd9;
                b = 8'd9;
                sub = 1'b1;
            end
            if (k == 4) start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        chk("busy_latency", lat, W + 1);
        chk("busy_result", int'(result), 2);
        chk("busy_carry", int'(carry_out), 0);
        repeat (14) @(negedge clk);
        chk("busy_done_cnt", done_cnt - d0, 1);
        chk("busy_ready_after", int'(ready), 1);

        // Reset in the middle of an operation.
        @(negedge clk);
        a = 8'd10;
        b = 8'd10;
        sub = 1'b0;
        start = 1'b1;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", int'(ready), 1);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_result", int'(result), 0);
        chk("mid_rst_carry", int'(carry_out), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("mid_rst_no_done", done_cnt - d0, 0);
        chk("mid_rst_ready_after", int'(ready), 1);
        do_op("post_rst", 8'd1, 8'd1, 1'b0, 8'd2, 1'b0);

`ifdef SERIAL_ADD_SUB_OVF_EN
        do_op("ovf_a", 8'd127, 8'd1, 1'b0, 8'd128, 1'b0);
        chk("ovf_a_flag", int'(ovf), 1);
        do_op("ovf_b", 8'd128, 8'd1, 1'b1, 8'd127, 1'b1);
        chk("ovf_b_flag", int'(ovf), 1);
        do_op("ovf_c", 8'd3, 8'd5, 1'b0, 8'd8, 1'b0);
        chk("ovf_c_flag", int'(ovf), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
